// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for an asynchronous FIFO: synchronises the write
// Gray pointer, tracks the read pointer and derives empty, fill level and underflow.

module gray_to_binary #(
    parameter int PTR = 5
) (
    input  logic [PTR-1:0] gray,
    output logic [PTR-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < PTR; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

module fifo_rd_ptr_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    input  logic              rd_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    localparam int PTR = ADDR_W + 1;

    logic [PTR-1:0] wr_gray_s1_q, wr_gray_s1_d;
    logic [PTR-1:0] wr_gray_s2_q, wr_gray_s2_d;
    logic [PTR-1:0] rd_bin_q,     rd_bin_d;
    logic [PTR-1:0] rd_gray_q,    rd_gray_d;
    logic           empty_q,      empty_d;
    logic [PTR-1:0] rd_level_q,   rd_level_d;
    logic           underflow_q,  underflow_d;

    logic [PTR-1:0] wr_bin_sync_s;
    logic           rd_en_s;

    gray_to_binary #(
        .PTR (PTR)
    ) u_wr_g2b (
        .gray (wr_gray_s2_q),
        .bin  (wr_bin_sync_s)
    );

    // Next-state logic: pop acceptance, pointer advance and flag computation.
    always_comb begin
        rd_en_s      = rd_req & ~empty_q;
        wr_gray_s1_d = wr_ptr_gray;
        wr_gray_s2_d = wr_gray_s1_q;
        rd_bin_d     = rd_bin_q + {{(PTR-1){1'b0}}, rd_en_s};
        rd_gray_d    = rd_bin_d ^ (rd_bin_d >> 1);
        // Flags look at the post-pop pointer so a pop and a sync update in the
        // same cycle are both reflected without losing a count.
        empty_d      = (rd_gray_d == wr_gray_s2_q);
        rd_level_d   = wr_bin_sync_s - rd_bin_d;
        underflow_d  = rd_req & empty_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_gray_s1_q <= {PTR{1'b0}};
            wr_gray_s2_q <= {PTR{1'b0}};
            rd_bin_q     <= {PTR{1'b0}};
            rd_gray_q    <= {PTR{1'b0}};
            empty_q      <= 1'b1;
            rd_level_q   <= {PTR{1'b0}};
            underflow_q  <= 1'b0;
        end else begin
            wr_gray_s1_q <= wr_gray_s1_d;
            wr_gray_s2_q <= wr_gray_s2_d;
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= rd_gray_d;
            empty_q      <= empty_d;
            rd_level_q   <= rd_level_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rd_en       = rd_en_s;
    assign rd_addr     = rd_bin_q[ADDR_W-1:0];
    assign rd_ptr_gray = rd_gray_q;
    assign empty       = empty_q;
    assign rd_level    = rd_level_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed self-checking bench for fifo_rd_ptr_ctrl (ADDR_W = 4).

module tb_fifo_rd_ptr_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] wr_ptr_gray;
    logic       rd_req;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr_gray;
    logic       empty;
    logic [4:0] rd_level;
    logic       underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_rd_ptr_ctrl #(.ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_req      (rd_req),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .empty       (empty),
        .rd_level    (rd_level),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; checks the Gray pointer
    // never moves more than one bit on an edge taken out of reset.
    task automatic step();
        logic [4:0] prev_g;
        logic       was_run;
        prev_g  = rd_ptr_gray;
        was_run = rst_n;
        @(posedge clk);
        #1;
        if (was_run) chk("gray_1bit", 32'($countones(prev_g ^ rd_ptr_gray) <= 1), 32'd1);
    endtask

    task automatic chk_state(input string tag, input logic e, input logic [4:0] lvl,
                             input logic [4:0] g, input logic uf);
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_level"}, 32'(rd_level), 32'(lvl));
        chk({tag, "_gray"},  32'(rd_ptr_gray), 32'(g));
        chk({tag, "_uflow"}, 32'(underflow), 32'(uf));
    endtask

    initial begin
        // Reset with activity on the inputs
        rst_n = 1'b0; wr_ptr_gray = 5'h0C; rd_req = 1'b1;
        step(); step();
        chk_state("rst", 1'b1, 5'd0, 5'h00, 1'b0);
        chk("rst_rden", 32'(rd_en), 32'd0);

        // Sync latency: empty falls on the 3rd edge after the write pointer moves
        rst_n = 1'b1; rd_req = 1'b0; wr_ptr_gray = 5'h01;
        step(); chk("lat_e1", 32'(empty), 32'd1);
        step(); chk("lat_e2", 32'(empty), 32'd1);
        step(); chk_state("lat_e3", 1'b0, 5'd1, 5'h00, 1'b0);
        rd_req = 1'b1; #1;
        chk("lat_rden", 32'(rd_en), 32'd1);
        chk("lat_addr", 32'(rd_addr), 32'd0);
        step(); rd_req = 1'b0;
        chk_state("lat_pop", 1'b1, 5'd0, 5'h01, 1'b0);

        // Fill and drain from a fresh reset: 16 entries available
        rst_n = 1'b0; step();
        rst_n = 1'b1; wr_ptr_gray = 5'h18;
        step(); step(); step();
        chk_state("fill", 1'b0, 5'd16, 5'h00, 1'b0);
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_rden", 32'(rd_en), 32'd1);
            chk("drain_addr", 32'(rd_addr), 32'(i));
            chk("drain_level", 32'(rd_level), 32'(16 - i));
            step();
        end
        chk_state("drained", 1'b1, 5'd0, 5'h18, 1'b0);
        chk("uf_rden", 32'(rd_en), 32'd0);
        step();
        chk("uf_pulse", 32'(underflow), 32'd1);
        chk("uf_ptr", 32'(rd_ptr_gray), 32'h18);
        rd_req = 1'b0;
        step();
        chk("uf_clear", 32'(underflow), 32'd0);

        // Wrap: bring rd_bin to 30, then follow the write pointer across the wrap
        wr_ptr_gray = 5'h11;
        step(); step(); step();
        chk("wrap_lvl14", 32'(rd_level), 32'd14);
        rd_req = 1'b1;
        for (int i = 0; i < 14; i++) step();
        rd_req = 1'b0;
        chk_state("at30", 1'b1, 5'd0, 5'h11, 1'b0);
        wr_ptr_gray = 5'h10;
        step(); step(); step();
        chk("w31_level", 32'(rd_level), 32'd1);
        rd_req = 1'b1; #1;
        chk("w31_addr", 32'(rd_addr), 32'd14);
        step(); rd_req = 1'b0;
        chk_state("w31_pop", 1'b1, 5'd0, 5'h10, 1'b0);
        wr_ptr_gray = 5'h00;
        step(); step(); step();
        chk("w0_level", 32'(rd_level), 32'd1);
        rd_req = 1'b1; #1;
        chk("w0_addr", 32'(rd_addr), 32'd15);
        step(); rd_req = 1'b0;
        chk_state("w0_pop", 1'b1, 5'd0, 5'h00, 1'b0);
        wr_ptr_gray = 5'h01;
        step(); step(); step();
        rd_req = 1'b1; #1;
        chk("w1_addr", 32'(rd_addr), 32'd0);
        step(); rd_req = 1'b0;
        chk_state("w1_pop", 1'b1, 5'd0, 5'h01, 1'b0);

        // Simultaneous pop and sync advance: level stays 3
        wr_ptr_gray = 5'h06;
        step(); step(); step();
        chk("sim_lvl3", 32'(rd_level), 32'd3);
        wr_ptr_gray = 5'h07;
        step(); step();
        chk("sim_pre", 32'(rd_level), 32'd3);
        rd_req = 1'b1; #1;
        chk("sim_rden", 32'(rd_en), 32'd1);
        chk("sim_addr", 32'(rd_addr), 32'd1);
        step(); rd_req = 1'b0;
        chk_state("sim", 1'b0, 5'd3, 5'h03, 1'b0);

        // Mid-operation reset with reads in flight, then resync of bin 8
        wr_ptr_gray = 5'h0F;
        step(); step(); step();
        chk("mid_lvl8", 32'(rd_level), 32'd8);
        rd_req = 1'b1;
        step();
        chk("mid_lvl7", 32'(rd_level), 32'd7);
        rst_n = 1'b0; wr_ptr_gray = 5'h0C;
        step();
        chk_state("mid_rst", 1'b1, 5'd0, 5'h00, 1'b0);
        chk("mid_rden", 32'(rd_en), 32'd0);
        chk("mid_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1; rd_req = 1'b0;
        step(); chk("resync_e1", 32'(empty), 32'd1);
        step(); chk("resync_e2", 32'(empty), 32'd1);
        step(); chk_state("resync", 1'b0, 5'd8, 5'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
